// File: rtl/flash_wb_ctrl.sv
// Wishbone B3 classic slave for a byte-wide parallel NOR flash. Each bus read
// becomes four timed byte reads assembled big-endian; bus writes are acked and dropped.
module flash_wb_ctrl #(
    parameter int WAIT_CYCLES = 4,
    parameter int FLASH_AW    = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [31:0]         wb_adr_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    input  logic [7:0]          flash_data_i,
    output logic [FLASH_AW-1:0] flash_addr_o,
    output logic                flash_ce_o,
    output logic                flash_oe_o,
    output logic                flash_we_o,
    output logic                flash_rst_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RACK,
        WACK
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            wait_cnt;
    logic [3:0]            wait_cnt_nxt;
    logic [1:0]            byte_idx;
    logic [1:0]            byte_idx_nxt;
    logic                  ack_nxt;
    logic [31:0]           dat_nxt;
    logic [FLASH_AW-1:0]   addr_nxt;
    logic                  ce_nxt;
    logic                  oe_nxt;
    logic                  req_valid;
    logic                  unused_inputs;

    assign req_valid     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign flash_we_o    = 1'b1;
    assign unused_inputs = ^{wb_sel_i, wb_dat_i, wb_adr_i[31:FLASH_AW], wb_adr_i[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            byte_idx     <= 2'd0;
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= 32'd0;
            flash_addr_o <= '0;
            flash_ce_o   <= 1'b1;
            flash_oe_o   <= 1'b1;
            flash_rst_o  <= 1'b0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            byte_idx     <= byte_idx_nxt;
            wb_ack_o     <= ack_nxt;
            wb_dat_o     <= dat_nxt;
            flash_addr_o <= addr_nxt;
            flash_ce_o   <= ce_nxt;
            flash_oe_o   <= oe_nxt;
            flash_rst_o  <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        byte_idx_nxt = byte_idx;
        ack_nxt      = wb_ack_o;
        dat_nxt      = wb_dat_o;
        addr_nxt     = flash_addr_o;
        ce_nxt       = flash_ce_o;
        oe_nxt       = flash_oe_o;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (wb_we_i) begin
                        // cyc is known high here, so a write ack is never suppressed
                        state_nxt = WACK;
                        ack_nxt   = 1'b1;
                    end else begin
                        state_nxt    = READ;
                        addr_nxt     = {wb_adr_i[FLASH_AW-1:2], 2'b00};
                        ce_nxt       = 1'b0;
                        oe_nxt       = 1'b0;
                        wait_cnt_nxt = 4'd0;
                        byte_idx_nxt = 2'd0;
                    end
                end
            end

            READ: begin
                // Abort wins over sampling, which also covers ack suppression on the last byte
                if (!wb_cyc_i) begin
                    state_nxt = IDLE;
                    ce_nxt    = 1'b1;
                    oe_nxt    = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    wait_cnt_nxt = 4'd0;
                    case (byte_idx)
                        2'd0:    dat_nxt[31:24] = flash_data_i;
                        2'd1:    dat_nxt[23:16] = flash_data_i;
                        2'd2:    dat_nxt[15:8]  = flash_data_i;
                        default: dat_nxt[7:0]   = flash_data_i;
                    endcase
                    if (byte_idx == 2'd3) begin
                        state_nxt = RACK;
                        ack_nxt   = 1'b1;
                        ce_nxt    = 1'b1;
                        oe_nxt    = 1'b1;
                    end else begin
                        byte_idx_nxt  = byte_idx + 2'd1;
                        addr_nxt[1:0] = flash_addr_o[1:0] + 2'd1;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end

            RACK: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
            end

            WACK: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_flash_wb_ctrl.sv
// Bench for flash_wb_ctrl: instance u0 runs WAIT_CYCLES=4, u1 runs WAIT_CYCLES=1,
// each wired to a flash that returns the low byte of its address.
module tb_flash_wb_ctrl;

    localparam int AW = 22;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      cyc;
    logic [1:0]      stb;
    logic [1:0]      we;
    logic [1:0][31:0] adr;
    logic [1:0][31:0] wdat;
    logic [1:0][3:0]  sel;
    logic [1:0][31:0] dat;
    logic [1:0]      ack;
    logic [1:0][7:0] fdat;
    logic [1:0][AW-1:0] faddr;
    logic [1:0]      ce;
    logic [1:0]      oe;
    logic [1:0]      fwe;
    logic [1:0]      frst;

    int              n_tests = 0;
    int              n_fail = 0;
    int              cycle = 0;
    logic [31:0]     model_dat [2];
    vec_t            tbl [7];

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign fdat[0] = faddr[0][7:0];
    assign fdat[1] = faddr[1][7:0];

    flash_wb_ctrl #(.WAIT_CYCLES(4), .FLASH_AW(AW)) u0 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]), .wb_adr_i(adr[0]),
        .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(dat[0]), .wb_ack_o(ack[0]),
        .flash_data_i(fdat[0]), .flash_addr_o(faddr[0]), .flash_ce_o(ce[0]),
        .flash_oe_o(oe[0]), .flash_we_o(fwe[0]), .flash_rst_o(frst[0])
    );

    flash_wb_ctrl #(.WAIT_CYCLES(1), .FLASH_AW(AW)) u1 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]), .wb_adr_i(adr[1]),
        .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(dat[1]), .wb_ack_o(ack[1]),
        .flash_data_i(fdat[1]), .flash_addr_o(faddr[1]), .flash_ce_o(ce[1]),
        .flash_oe_o(oe[1]), .flash_we_o(fwe[1]), .flash_rst_o(frst[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int wait_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // The word a read of byte address a must return
    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic run_txn(input int i, input bit w_en, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] exp,
                           input bit hold, input bit stb_jitter, output int ack_cycle);
        int          w;
        int          lat;
        int          n;
        bit          seen;
        bit          ce_ok;
        bit          addr_ok;
        logic [AW-1:0] base;
        w = wait_of(i);
        lat = w_en ? 0 : 4 * w;
        base = {a[AW-1:2], 2'b00};
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w_en; adr[i] = a; wdat[i] = wd;
        sel[i] = 4'($urandom);
        seen = 0; ce_ok = 1; addr_ok = 1; n = 0;
        @(posedge clk); #1;
        while (n <= lat + 3) begin
            if (!w_en && n < lat) begin
                if (ce[i] !== 1'b0 || oe[i] !== 1'b0) ce_ok = 0;
                if (faddr[i] !== base + AW'(n / w)) addr_ok = 0;
            end else if (ce[i] !== 1'b1 || oe[i] !== 1'b1) begin
                ce_ok = 0;
            end
            if (fwe[i] !== 1'b1) ce_ok = 0;
            if (ack[i] === 1'b1) begin
                seen = 1;
                break;
            end
            if (stb_jitter && !w_en) stb[i] = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        ack_cycle = cycle;
        check($sformatf("u%0d.ack_seen a=%0h", i, a), 32'(seen), 32'd1);
        check($sformatf("u%0d.ack_latency a=%0h", i, a), n, lat);
        check($sformatf("u%0d.data a=%0h", i, a), dat[i], exp);
        check($sformatf("u%0d.strobes a=%0h", i, a), 32'(ce_ok), 32'd1);
        if (!w_en) begin
            check($sformatf("u%0d.addr_steps a=%0h", i, a), 32'(addr_ok), 32'd1);
            check($sformatf("u%0d.addr_final a=%0h", i, a), 32'(faddr[i]), 32'(base + AW'(3)));
        end
        if (!hold) begin
            cyc[i] = 1'b0;
            stb[i] = 1'b0;
        end else begin
            stb[i] = 1'b1;
        end
        @(posedge clk); #1;
        check($sformatf("u%0d.ack_width a=%0h", i, a), 32'(ack[i]), 32'd0);
        model_dat[i] = exp;
    endtask

    // Drop cyc so that it is sampled low at edge E0+d
    task automatic run_abort(input int i, input logic [31:0] a, input int d);
        int          w;
        bit          ack_any;
        logic [31:0] full;
        logic [31:0] e;
        w = wait_of(i);
        full = model_word(a);
        e = model_dat[i];
        for (int k = 0; k < 4; k++)
            if ((k + 1) * w < d) e[31 - 8 * k -: 8] = full[31 - 8 * k -: 8];
        ack_any = 0;
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b0; adr[i] = a;
        @(posedge clk); #1;
        for (int n = 0; n < d - 1; n++) begin
            if (ack[i] === 1'b1) ack_any = 1;
            @(posedge clk); #1;
        end
        cyc[i] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("u%0d.abort_ce d=%0d", i, d), {30'd0, ce[i], oe[i]}, 32'd3);
        repeat (4 * w + 4) begin
            if (ack[i] === 1'b1) ack_any = 1;
            @(posedge clk); #1;
        end
        check($sformatf("u%0d.abort_no_ack d=%0d", i, d), 32'(ack_any), 32'd0);
        check($sformatf("u%0d.abort_partial d=%0d", i, d), dat[i], e);
        stb[i] = 1'b0;
        model_dat[i] = e;
    endtask

    // Assert rst asynchronously a few time units after edge E0+d
    task automatic run_reset_mid(input int i, input logic [31:0] a, input int d);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b0; adr[i] = a;
        @(posedge clk); #1;
        repeat (d) begin
            @(posedge clk); #1;
        end
        #3 rst = 1'b0;
        #1;
        check($sformatf("u%0d.async_ce_oe", i), {30'd0, ce[i], oe[i]}, 32'd3);
        check($sformatf("u%0d.async_ack", i), 32'(ack[i]), 32'd0);
        check($sformatf("u%0d.async_frst", i), 32'(frst[i]), 32'd0);
        check($sformatf("u%0d.async_dat", i), dat[i], 32'd0);
        cyc[i] = 1'b0; stb[i] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check($sformatf("u%0d.async_release_frst", i), 32'(frst[i]), 32'd1);
        model_dat[0] = 32'd0;
        model_dat[1] = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        int c2;
        int kind;
        int i;
        int d;
        logic [31:0] a;

        tbl[0] = '{1'b0, 32'h0000_0010, 32'h0,         32'h1011_1213};
        tbl[1] = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'h1011_1213};
        tbl[2] = '{1'b0, 32'h003F_FFFC, 32'h0,         32'hFCFD_FEFF};
        tbl[3] = '{1'b0, 32'hFFC0_0013, 32'h0,         32'h1011_1213};
        tbl[4] = '{1'b0, 32'h0000_00F8, 32'h0,         32'hF8F9_FAFB};
        tbl[5] = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'hF8F9_FAFB};
        tbl[6] = '{1'b0, 32'h0012_34FC, 32'h0,         32'hFCFD_FEFF};

        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
        model_dat[0] = 32'd0;
        model_dat[1] = 32'd0;
        #1 rst = 1'b0;

        repeat (5) begin
            @(posedge clk); #1;
            cyc = 2'($urandom); stb = 2'($urandom); we = 2'($urandom);
            adr[0] = $urandom; adr[1] = $urandom;
            for (int j = 0; j < 2; j++) begin
                check($sformatf("u%0d.reset_ctl", j),
                      {27'd0, ce[j], oe[j], fwe[j], frst[j], ack[j]}, 32'b11100);
                check($sformatf("u%0d.reset_dat", j), dat[j], 32'd0);
                check($sformatf("u%0d.reset_addr", j), 32'(faddr[j]), 32'd0);
            end
        end
        cyc = '0; stb = '0; we = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        #2;
        check("u0.frst_before_edge", 32'(frst[0]), 32'd0);
        @(posedge clk); #1;
        check("u0.frst_after_edge", 32'(frst[0]), 32'd1);
        check("u1.frst_after_edge", 32'(frst[1]), 32'd1);

        for (int j = 0; j < 2; j++)
            for (int t = 0; t < 7; t++)
                run_txn(j, tbl[t].we, tbl[t].adr, tbl[t].wd, tbl[t].exp, 1'b0, 1'b0, c1);

        for (int j = 0; j < 2; j++) begin
            run_txn(j, 1'b0, 32'h00, 32'h0, 32'h0001_0203, 1'b1, 1'b0, c1);
            run_txn(j, 1'b0, 32'h04, 32'h0, 32'h0405_0607, 1'b0, 1'b0, c2);
            check($sformatf("u%0d.b2b_spacing", j), c2 - c1, 4 * wait_of(j) + 2);
        end

        run_abort(0, 32'h08, 6);
        run_txn(0, 1'b0, 32'h08, 32'h0, 32'h0809_0A0B, 1'b0, 1'b0, c1);
        run_abort(0, 32'h30, 16);
        run_abort(1, 32'h40, 4);
        run_txn(1, 1'b0, 32'h08, 32'h0, 32'h0809_0A0B, 1'b0, 1'b0, c1);

        run_reset_mid(0, 32'h0C, 9);
        run_txn(0, 1'b0, 32'h0C, 32'h0, 32'h0C0D_0E0F, 1'b0, 1'b0, c1);
        run_reset_mid(1, 32'h0C, 2);
        run_txn(1, 1'b0, 32'h0C, 32'h0, 32'h0C0D_0E0F, 1'b0, 1'b0, c1);

        for (int it = 0; it < 60; it++) begin
            i = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            a = $urandom;
            if (kind < 6) begin
                run_txn(i, 1'b0, a, $urandom, model_word(a), 1'b0, kind[0], c1);
            end else if (kind < 8) begin
                run_txn(i, 1'b1, a, $urandom, model_dat[i], 1'b0, 1'b0, c1);
            end else begin
                d = int'($urandom_range(1, 4 * wait_of(i)));
                run_abort(i, a, d);
            end
            repeat ($urandom_range(0, 2)) begin
                cyc[i] = 1'($urandom);
                @(posedge clk); #1;
            end
            cyc[i] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/flash_wb_ctrl.md
Name: flash_wb_ctrl

Overview:
- Wishbone B3 classic slave that sequences the byte-wide parallel NOR flash on the SoC bus.
- Turns each 32-bit Wishbone read into four timed byte reads, assembles the word big-endian (MIPS order), then acks.
- Flash is read-only from the bus; writes are acked and discarded.
- Sits between the bus interconnect flash slave port and the top-level flash pins.

Parameters:
- WAIT_CYCLES, 4, clk cycles each byte address is held before flash_data_i is sampled; legal range 1..15.
- FLASH_AW, 22, flash byte-address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_adr_i  in  32  byte address; bits [FLASH_AW-1:2] used.
- wb_sel_i  in  4  byte select; ignored, reads always return the full word.
- wb_dat_i  in  32  write data; ignored.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- flash_data_i  in  8  flash data bus.
- flash_addr_o  out  FLASH_AW  flash byte address.
- flash_ce_o  out  1  chip enable, active-low.
- flash_oe_o  out  1  output enable, active-low.
- flash_we_o  out  1  write enable, active-low; constant 1.
- flash_rst_o  out  1  flash reset, active-low.

Behaviour:
- Reset (rst=0, async): state IDLE, wb_ack_o=0, wb_dat_o=0, flash_addr_o=0, flash_ce_o=1, flash_oe_o=1, flash_we_o=1, flash_rst_o=0, byte index=0, wait counter=0.
- Out of reset, flash_rst_o goes 1 on the first clk edge and stays 1.
- All outputs are registered.
- Request is valid when wb_cyc_i & wb_stb_i are both 1 and wb_ack_o is 0.
- States:
  - IDLE -> READ: valid request with wb_we_i=0 at edge E0.
  - IDLE -> WACK: valid request with wb_we_i=1.
  - READ -> RACK: after the 4th byte is sampled.
  - RACK -> IDLE.
  - WACK -> IDLE.
- READ, on entry at E0:
  - flash_addr_o = {wb_adr_i[FLASH_AW-1:2], 2'b00}.
  - flash_ce_o = 0, flash_oe_o = 0.
  - Wait counter and byte index k are cleared.
- READ, byte k (k = 0..3):
  - Sampled at edge E0 + (k+1)*WAIT_CYCLES into wb_dat_o[31-8k -: 8].
  - Byte 0 goes to [31:24]; byte 3 goes to [7:0].
  - On the same edge flash_addr_o[1:0] increments; after byte 3 it is left unchanged.
- Sampling the 4th byte, at edge E0 + 4*WAIT_CYCLES:
  - wb_ack_o = 1, flash_ce_o = 1, flash_oe_o = 1, state RACK.
- RACK: next edge sets wb_ack_o = 0 and returns to IDLE.
- Read latency: ack is visible to the master at edge E0 + 4*WAIT_CYCLES + 1.
- wb_dat_o holds its value until the next read overwrites bytes in progress. Partially assembled words are visible during READ; masters use data only with ack.
- Write: WACK drives wb_ack_o = 1 for one cycle, then returns to IDLE. flash_ce_o and flash_oe_o stay 1, wb_dat_o is unchanged, and there is no flash activity.
- Back-to-back: a request still asserted in the cycle after ack (the IDLE cycle) starts a new transaction. Minimum one idle cycle between acks.
- Abort: wb_cyc_i=0 sampled in READ gives, on that edge:
  - state IDLE, flash_ce_o = 1, flash_oe_o = 1, no ack.
  - Partial wb_dat_o bytes are retained.
- wb_stb_i dropping alone while wb_cyc_i=1 does not abort.
- Ack suppression: if wb_cyc_i=0 at the edge that would set ack (last-byte edge or WACK entry), ack is not raised.
- Async reset mid-read: outputs return to reset values immediately. Next read restarts from byte 0.
- Wait counter is 4 bits, counts 0..WAIT_CYCLES-1 and wraps per byte. WAIT_CYCLES=1 samples on every edge: 4 edges of READ.
- flash_addr_o upper bits never change during a transaction. Adding to the byte index never carries into bit 2.

Test Plan:
- Reset check: hold rst=0 with random inputs -> ce=1, oe=1, we=1, flash_rst_o=0, ack=0, dat_o=0. Release -> flash_rst_o=1 one edge later.
- Single read, WAIT_CYCLES=4, adr=0x0000_0010, flash model returns low address byte:
  - flash_addr_o steps 0x10, 0x11, 0x12, 0x13, each held 4 cycles.
  - ack seen at E0+17 for exactly 1 cycle with dat_o=0x10111213.
  - ce/oe low for edges E0..E0+15 only.
- Write, adr=0x20, dat=0xDEADBEEF -> ack at E0+1 for one cycle, ce/oe never low, dat_o unchanged.
- Back-to-back reads at 0x00 then 0x04, stb held high -> two acks 18 cycles apart, data 0x00010203 then 0x04050607.
- Abort: drop cyc at E0+6 -> ce/oe high after that edge, no ack ever. Next read at 0x08 returns 0x08090A0B.
- Async reset at E0+9 mid-read -> ce/oe go high within the same cycle (no clk edge needed), ack never seen. After release, a read of 0x0C returns 0x0C0D0E0F. Repeat with WAIT_CYCLES=1 -> ack at E0+5.
